// File: rtl/pc_pkg.sv
// Shared types and constants for the RV32I program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_INC    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JALR   = 2'b10,
        PC_TRAP   = 2'b11
    } pc_src_t;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_target_sel.sv
// Combinational next-PC target formation: builds the four candidate targets,
// forces alignment and redirects misaligned branch/jalr targets to the trap vector.
module pc_target_sel
    import pc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [1:0]       pc_src,
    input  logic [WIDTH-1:0] imm_op,
    input  logic [WIDTH-1:0] jalr_target,
    input  logic [WIDTH-1:0] trap_vector,
    output logic [WIDTH-1:0] target,
    output logic             misalign,
    output logic             is_trap
);

    logic [WIDTH-1:0] inc_target;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jalr_aligned;
    logic [WIDTH-1:0] trap_aligned;
    logic             unused_low_bits;

    assign inc_target    = pc + WIDTH'(PC_STEP);
    assign branch_target = pc + imm_op;
    assign jalr_aligned  = {jalr_target[WIDTH-1:1], 1'b0};
    assign trap_aligned  = {trap_vector[WIDTH-1:2], 2'b00};

    // Bits discarded by alignment forcing are intentionally ignored.
    assign unused_low_bits = ^{jalr_target[0], trap_vector[1:0]};

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        target   = inc_target;
        misalign = 1'b0;
        is_trap  = 1'b0;
        case (pc_src_t'(pc_src))
            PC_INC: begin
                target = inc_target;
            end
            PC_BRANCH: begin
                misalign = branch_target[1];
                target   = misalign ? trap_aligned : branch_target;
                is_trap  = misalign;
            end
            PC_JALR: begin
                misalign = jalr_aligned[1];
                target   = misalign ? trap_aligned : jalr_aligned;
                is_trap  = misalign;
            end
            PC_TRAP: begin
                target  = trap_aligned;
                is_trap = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Registered program-counter generator with fetch stall, pending-redirect buffer
// and misalignment trap. Optional retire counter built when PC_GEN_RETIRE_CNT_EN is defined.
module pc_gen
    import pc_pkg::*;
#(
    parameter int                WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int                CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic [1:0]           PCsrc,
    input  logic [WIDTH-1:0]     ImmOp,
    input  logic [WIDTH-1:0]     jalr_target,
    input  logic [WIDTH-1:0]     trap_vector,
    output logic [WIDTH-1:0]     PC,
    output logic [WIDTH-1:0]     PC_plus4,
    output logic                 misaligned,
    output logic [CNT_WIDTH-1:0] retire_cnt
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    logic             pend_trap_q, pend_trap_d;
    logic             misaligned_q, misaligned_d;

    logic [WIDTH-1:0] sel_target;
    logic             sel_misalign;
    logic             sel_trap;
    logic             redirect;
    logic             keep_pending;

    pc_target_sel #(.WIDTH(WIDTH)) u_target_sel (
        .pc          (pc_q),
        .pc_src      (PCsrc),
        .imm_op      (ImmOp),
        .jalr_target (jalr_target),
        .trap_vector (trap_vector),
        .target      (sel_target),
        .misalign    (sel_misalign),
        .is_trap     (sel_trap)
    );

    assign redirect = (pc_src_t'(PCsrc) != PC_INC);
    // A buffered trap may only be displaced by another trap.
    assign keep_pending = pend_valid_q && pend_trap_q && !sel_trap;

    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pend_trap_d   = pend_trap_q;
        misaligned_d  = redirect && sel_misalign;

        if (stall) begin
            if (redirect && !keep_pending) begin
                pend_valid_d  = 1'b1;
                pend_target_d = sel_target;
                pend_trap_d   = sel_trap;
            end
        end else begin
            pend_valid_d = 1'b0;
            pend_trap_d  = 1'b0;
            pc_d         = (pend_valid_q && !redirect) ? pend_target_q : sel_target;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_VECTOR;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            pend_trap_q   <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            pend_trap_q   <= pend_trap_d;
            misaligned_q  <= misaligned_d;
        end
    end

`ifdef PC_GEN_RETIRE_CNT_EN
    logic [CNT_WIDTH-1:0] retire_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else if (!stall) begin
            retire_cnt_q <= retire_cnt_q + 1'b1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`else
    assign retire_cnt = '0;
`endif

    assign PC         = pc_q;
    assign PC_plus4   = pc_q + WIDTH'(PC_STEP);
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: the driver queues the expected post-edge state,
// a monitor pops and compares it after every rising edge.
module tb_pc_gen;
    import pc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [1:0]  PCsrc;
    logic [31:0] ImmOp;
    logic [31:0] jalr_target;
    logic [31:0] trap_vector;
    logic [31:0] PC;
    logic [31:0] PC_plus4;
    logic        misaligned;
    logic [31:0] retire_cnt;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_cnt  = 32'h0;

    pc_gen #(.WIDTH(32), .RESET_VECTOR(32'h0), .CNT_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .PCsrc       (PCsrc),
        .ImmOp       (ImmOp),
        .jalr_target (jalr_target),
        .trap_vector (trap_vector),
        .PC          (PC),
        .PC_plus4    (PC_plus4),
        .misaligned  (misaligned),
        .retire_cnt  (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at a falling edge and queue the state expected after the next rising edge.
    task automatic step(input string name, input logic st, input logic [1:0] src,
                        input logic [31:0] exp_pc, input logic exp_mis,
                        input logic [31:0] imm = 32'h0, input logic [31:0] jt = 32'h0,
                        input logic [31:0] tv = 32'h0);
        exp_t e;
        stall       = st;
        PCsrc       = src;
        ImmOp       = imm;
        jalr_target = jt;
        trap_vector = tv;
`ifdef PC_GEN_RETIRE_CNT_EN
        if (!st) exp_cnt = exp_cnt + 32'd1;
`endif
        e.name = name;
        e.pc   = exp_pc;
        e.mis  = exp_mis;
        e.cnt  = exp_cnt;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".pc"}, PC, e.pc);
                check({e.name, ".pc_plus4"}, PC_plus4, e.pc + 32'd4);
                check({e.name, ".misaligned"}, {31'b0, misaligned}, {31'b0, e.mis});
                check({e.name, ".retire_cnt"}, retire_cnt, e.cnt);
            end
        end
    end

    initial begin : driver
        rst_n       = 1'b0;
        stall       = 1'b0;
        PCsrc       = 2'b00;
        ImmOp       = '0;
        jalr_target = '0;
        trap_vector = '0;
        #12;
        check("reset.pc", PC, 32'h0);
        check("reset.pc_plus4", PC_plus4, 32'h4);
        check("reset.misaligned", {31'b0, misaligned}, 32'h0);
        check("reset.retire_cnt", retire_cnt, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch from the reset vector.
        step("inc0", 1'b0, PC_INC, 32'h4, 1'b0);
        step("inc1", 1'b0, PC_INC, 32'h8, 1'b0);
        step("inc2", 1'b0, PC_INC, 32'hC, 1'b0);

        // Backward branch and jalr with bit 0 cleared.
        step("jalr_100a", 1'b0, PC_JALR,   32'h100, 1'b0, 32'h0, 32'h100);
        step("br_back",   1'b0, PC_BRANCH, 32'h0F0, 1'b0, 32'hFFFF_FFF0);
        step("jalr_205",  1'b0, PC_JALR,   32'h204, 1'b0, 32'h0, 32'h205);

        // Misaligned branch goes to the aligned trap vector, pulse lasts one cycle.
        step("jalr_100b", 1'b0, PC_JALR,   32'h100, 1'b0, 32'h0, 32'h100);
        step("br_misal",  1'b0, PC_BRANCH, 32'h800, 1'b1, 32'h6, 32'h0, 32'h803);
        step("after_mis", 1'b0, PC_INC,    32'h804, 1'b0);

        // Branch captured under stall, released with inc.
        step("jalr_40",   1'b0, PC_JALR,   32'h40, 1'b0, 32'h0, 32'h40);
        step("st_br",     1'b1, PC_BRANCH, 32'h40, 1'b0, 32'h20);
        step("st_hold0",  1'b1, PC_INC,    32'h40, 1'b0);
        step("st_hold1",  1'b1, PC_INC,    32'h40, 1'b0);
        step("rel_br",    1'b0, PC_INC,    32'h60, 1'b0);
        step("post_rel",  1'b0, PC_INC,    32'h64, 1'b0);

        // Stored trap is not displaced by a later branch.
        step("st_trap",   1'b1, PC_TRAP,   32'h64, 1'b0, 32'h0, 32'h0, 32'h500);
        step("st_br_ign", 1'b1, PC_BRANCH, 32'h64, 1'b0, 32'h8);
        step("rel_trap",  1'b0, PC_INC,    32'h500, 1'b0);

        // New redirect on the release cycle beats the pending one.
        step("st_br2",    1'b1, PC_BRANCH, 32'h500, 1'b0, 32'h10);
        step("rel_jalr",  1'b0, PC_JALR,   32'h300, 1'b0, 32'h0, 32'h300);
        step("post_jalr", 1'b0, PC_INC,    32'h304, 1'b0);

        // Misaligned jalr under stall pulses at capture only.
        step("st_jmis",   1'b1, PC_JALR,   32'h304, 1'b1, 32'h0, 32'h20A, 32'h500);
        step("st_jhold",  1'b1, PC_INC,    32'h304, 1'b0);
        step("rel_jmis",  1'b0, PC_INC,    32'h500, 1'b0);

        // Wraparound at the top of the address space.
        step("jalr_top",  1'b0, PC_JALR,   32'hFFFF_FFFC, 1'b0, 32'h0, 32'hFFFF_FFFC);
        step("wrap",      1'b0, PC_INC,    32'h0, 1'b0);

        // Async reset while a redirect is pending discards it.
        step("jalr_80",   1'b0, PC_JALR,   32'h80, 1'b0, 32'h0, 32'h80);
        step("st_br3",    1'b1, PC_BRANCH, 32'h80, 1'b0, 32'h40);
        #2;
        rst_n = 1'b0;
        exp_cnt = 32'h0;
        #1;
        check("async_rst.pc", PC, 32'h0);
        check("async_rst.misaligned", {31'b0, misaligned}, 32'h0);
        check("async_rst.retire_cnt", retire_cnt, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_rel",   1'b0, PC_INC,    32'h4, 1'b0);

        // Counter: five unstalled edges in total, then two stalled.
        step("cnt1",      1'b0, PC_INC,    32'h8,  1'b0);
        step("cnt2",      1'b0, PC_INC,    32'hC,  1'b0);
        step("cnt3",      1'b0, PC_INC,    32'h10, 1'b0);
        step("cnt4",      1'b0, PC_INC,    32'h14, 1'b0);
        step("cnt_st0",   1'b1, PC_INC,    32'h14, 1'b0);
        step("cnt_st1",   1'b1, PC_INC,    32'h14, 1'b0);

        stall = 1'b1;
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
